// File: rtl/spread_pkg.sv
// Shared defaults and width helpers for the spread statistics block.
package spread_pkg;

  localparam int unsigned PRICE_W_DEF = 8;
  localparam int unsigned DEPTH_DEF   = 8;
  localparam int unsigned CNT_W_DEF   = 16;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  localparam int unsigned AW    = clog2(DEPTH_DEF);
  localparam int unsigned SUM_W = PRICE_W_DEF + AW;

endpackage

// File: rtl/spread_window_buf.sv
// Circular buffer of the last DEPTH spreads with a running sum and fill tracking.
module spread_window_buf
  import spread_pkg::*;
#(
  parameter int unsigned PRICE_W = PRICE_W_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF,
  localparam int unsigned PTR_W  = clog2(DEPTH),
  localparam int unsigned ACC_W  = PRICE_W + PTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push_i,
  input  logic [PRICE_W-1:0] din_i,
  input  logic               clear_i,
  output logic [ACC_W-1:0]   sum_o,
  output logic               full_o
);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  logic [PRICE_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W:0]     fill_q, fill_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic               full_q, full_d;

  // Evicted entry is the slot about to be overwritten; it is still zero until the window wraps.
  always_comb begin
    wptr_d = wptr_q;
    fill_d = fill_q;
    sum_d  = sum_q;
    full_d = full_q;
    if (clear_i) begin
      wptr_d = '0;
      fill_d = '0;
      sum_d  = '0;
      full_d = 1'b0;
    end else if (push_i) begin
      wptr_d = wptr_q + PTR_W'(1);
      sum_d  = sum_q + ACC_W'(din_i) - ACC_W'(mem_q[wptr_q]);
      fill_d = full_q ? fill_q : fill_q + (PTR_W + 1)'(1);
      full_d = full_q | (fill_d == DEPTH_CNT);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      fill_q <= '0;
      sum_q  <= '0;
      full_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      fill_q <= fill_d;
      sum_q  <= sum_d;
      full_q <= full_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clear_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i) begin
      mem_q[wptr_q] <= din_i;
    end
  end

  assign sum_o  = sum_q;
  assign full_o = full_q;

endmodule

// File: rtl/spread_stats.sv
// Two-stage match spread statistics: S1 registers |buy-sell|, S2 updates last/min/max/avg/count.
module spread_stats
  import spread_pkg::*;
#(
  parameter int unsigned PRICE_W = PRICE_W_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  localparam int unsigned PTR_W  = clog2(DEPTH),
  localparam int unsigned ACC_W  = PRICE_W + PTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable_count,
  input  logic               match_valid,
  input  logic [PRICE_W-1:0] buy_price,
  input  logic [PRICE_W-1:0] sell_price,
  input  logic               clear,
  output logic [PRICE_W-1:0] spread_last,
  output logic               buy_above,
  output logic [PRICE_W-1:0] spread_min,
  output logic [PRICE_W-1:0] spread_max,
  output logic [PRICE_W-1:0] spread_avg,
  output logic [CNT_W-1:0]   match_count,
  output logic               window_full,
  output logic               stats_valid
);

  logic               accept_c;
  logic               buy_gt_c;
  logic [PRICE_W-1:0] diff_c;

  logic               s1_valid_q;
  logic [PRICE_W-1:0] s1_diff_q;
  logic               s1_above_q;

  logic [PRICE_W-1:0] last_q, last_d;
  logic               above_q, above_d;
  logic [PRICE_W-1:0] min_q, min_d;
  logic [PRICE_W-1:0] max_q, max_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               valid_q, valid_d;

  logic [ACC_W-1:0]   win_sum;
  logic               win_full;

  // Subtract the smaller from the larger so the difference never wraps.
  always_comb begin
    accept_c = enable_count & match_valid & ~clear;
    buy_gt_c = buy_price > sell_price;
    diff_c   = buy_gt_c ? (buy_price - sell_price) : (sell_price - buy_price);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_diff_q  <= '0;
      s1_above_q <= 1'b0;
    end else begin
      s1_valid_q <= accept_c;
      if (accept_c) begin
        s1_diff_q  <= diff_c;
        s1_above_q <= buy_gt_c;
      end
    end
  end

  // S2: clear has priority over a sample leaving S1.
  always_comb begin
    last_d  = last_q;
    above_d = above_q;
    min_d   = min_q;
    max_d   = max_q;
    count_d = count_q;
    valid_d = valid_q;
    if (clear) begin
      last_d  = '0;
      above_d = 1'b0;
      min_d   = '0;
      max_d   = '0;
      count_d = '0;
      valid_d = 1'b0;
    end else if (s1_valid_q) begin
      last_d  = s1_diff_q;
      above_d = s1_above_q;
      min_d   = (!valid_q || s1_diff_q < min_q) ? s1_diff_q : min_q;
      max_d   = (!valid_q || s1_diff_q > max_q) ? s1_diff_q : max_q;
      count_d = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q  <= '0;
      above_q <= 1'b0;
      min_q   <= '0;
      max_q   <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      last_q  <= last_d;
      above_q <= above_d;
      min_q   <= min_d;
      max_q   <= max_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  spread_window_buf #(
    .PRICE_W (PRICE_W),
    .DEPTH   (DEPTH)
  ) u_window (
    .clk     (clk),
    .reset   (reset),
    .push_i  (s1_valid_q),
    .din_i   (s1_diff_q),
    .clear_i (clear),
    .sum_o   (win_sum),
    .full_o  (win_full)
  );

  assign spread_last = last_q;
  assign buy_above   = above_q;
  assign spread_min  = min_q;
  assign spread_max  = max_q;
  assign spread_avg  = PRICE_W'(win_sum >> PTR_W);
  assign match_count = count_q;
  assign window_full = win_full;
  assign stats_valid = valid_q;

endmodule

// File: tb/tb_spread_stats.sv
// Directed bench for spread_stats: history-queue model checked every cycle plus literal spot checks.
module tb_spread_stats;

  localparam int unsigned DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable_count;
  logic       match_valid;
  logic [7:0] buy_price;
  logic [7:0] sell_price;
  logic       clear;

  logic [7:0]  spread_last, spread_min, spread_max, spread_avg;
  logic        buy_above, window_full, stats_valid;
  logic [15:0] match_count;

  logic [7:0] l4_last, l4_min, l4_max, l4_avg;
  logic       l4_above, l4_full, l4_valid;
  logic [3:0] l4_count;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  spread_stats u_dut (
    .clk(clk), .reset(reset), .enable_count(enable_count), .match_valid(match_valid),
    .buy_price(buy_price), .sell_price(sell_price), .clear(clear),
    .spread_last(spread_last), .buy_above(buy_above), .spread_min(spread_min),
    .spread_max(spread_max), .spread_avg(spread_avg), .match_count(match_count),
    .window_full(window_full), .stats_valid(stats_valid)
  );

  spread_stats #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .enable_count(enable_count), .match_valid(match_valid),
    .buy_price(buy_price), .sell_price(sell_price), .clear(clear),
    .spread_last(l4_last), .buy_above(l4_above), .spread_min(l4_min),
    .spread_max(l4_max), .spread_avg(l4_avg), .match_count(l4_count),
    .window_full(l4_full), .stats_valid(l4_valid)
  );

  typedef struct {
    int spread;
    bit above;
  } samp_t;

  samp_t hist[$];
  bit    pend_v = 0;
  samp_t pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: every accepted match lands in the history one edge after it is accepted.
  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset || clear) begin
        hist.delete();
        pend_v = 0;
      end else begin
        if (pend_v) hist.push_back(pend);
        pend_v = enable_count && match_valid;
        pend.spread = (buy_price > sell_price) ? int'(buy_price) - int'(sell_price)
                                               : int'(sell_price) - int'(buy_price);
        pend.above = buy_price > sell_price;
      end
    end
  end

  // Compare both DUTs against statistics recomputed from the history every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && !reset) begin
        int n, e_last, e_min, e_max, e_sum, e_cnt, e_cnt4, lo;
        bit e_above;
        n = hist.size();
        e_last = 0; e_above = 0; e_min = 0; e_max = 0; e_sum = 0;
        if (n > 0) begin
          e_last  = hist[n-1].spread;
          e_above = hist[n-1].above;
          e_min   = 256;
          for (int i = 0; i < n; i++) begin
            if (hist[i].spread < e_min) e_min = hist[i].spread;
            if (hist[i].spread > e_max) e_max = hist[i].spread;
          end
          lo = (n > DEPTH) ? n - DEPTH : 0;
          for (int i = lo; i < n; i++) e_sum += hist[i].spread;
        end
        e_cnt  = (n > 65535) ? 65535 : n;
        e_cnt4 = (n > 15) ? 15 : n;
        chk("last",  32'(spread_last), 32'(e_last));
        chk("above", 32'(buy_above),   32'(e_above));
        chk("min",   32'(spread_min),  32'(e_min));
        chk("max",   32'(spread_max),  32'(e_max));
        chk("avg",   32'(spread_avg),  32'(e_sum / DEPTH));
        chk("count", 32'(match_count), 32'(e_cnt));
        chk("full",  32'(window_full), 32'(n >= DEPTH));
        chk("valid", 32'(stats_valid), 32'(n > 0));
        chk("count4", 32'(l4_count),   32'(e_cnt4));
        chk("last4",  32'(l4_last),    32'(e_last));
        chk("avg4",   32'(l4_avg),     32'(e_sum / DEPTH));
        chk("max4",   32'(l4_max),     32'(e_max));
        chk("min4",   32'(l4_min),     32'(e_min));
        chk("above4", 32'(l4_above),   32'(e_above));
        chk("full4",  32'(l4_full),    32'(n >= DEPTH));
        chk("valid4", 32'(l4_valid),   32'(n > 0));
      end
    end
  end

  task automatic drv(input bit en, input bit mv, input int b, input int s, input bit clr);
    @(negedge clk);
    enable_count = en;
    match_valid  = mv;
    buy_price    = 8'(b);
    sell_price   = 8'(s);
    clear        = clr;
  endtask

  task automatic idle2();
    drv(1, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    enable_count = 1'b0;
    match_valid = 1'b0;
    buy_price = '0;
    sell_price = '0;
    clear = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1;

    drv(1, 0, 0, 0, 0);
    chk("rst_count", 32'(match_count), 32'd0);
    chk("rst_valid", 32'(stats_valid), 32'd0);

    // First sample: 100 vs 90.
    drv(1, 1, 100, 90, 0);
    idle2();
    chk("t1_last",  32'(spread_last), 32'd10);
    chk("t1_above", 32'(buy_above),   32'd1);
    chk("t1_min",   32'(spread_min),  32'd10);
    chk("t1_max",   32'(spread_max),  32'd10);
    chk("t1_avg",   32'(spread_avg),  32'd1);
    chk("t1_full",  32'(window_full), 32'd0);

    // Sell above buy, then equal prices.
    drv(1, 1, 50, 80, 0);
    drv(1, 1, 70, 70, 0);
    idle2();
    chk("t2_last",  32'(spread_last), 32'd0);
    chk("t2_above", 32'(buy_above),   32'd0);
    chk("t2_min",   32'(spread_min),  32'd0);
    chk("t2_max",   32'(spread_max),  32'd30);
    chk("t2_count", 32'(match_count), 32'd3);

    // Fill window with 8..64 then push a zero.
    drv(1, 0, 0, 0, 1);
    for (int k = 1; k <= 8; k++) drv(1, 1, 8 * k, 0, 0);
    idle2();
    chk("t3_full",  32'(window_full), 32'd1);
    chk("t3_avg",   32'(spread_avg),  32'd36);
    chk("t3_count", 32'(match_count), 32'd8);
    drv(1, 1, 5, 5, 0);
    idle2();
    chk("t3_avg9",  32'(spread_avg),  32'd35);
    chk("t3_min9",  32'(spread_min),  32'd0);
    chk("t3_max9",  32'(spread_max),  32'd64);

    // Disabled match is ignored; clear beats a simultaneous accept.
    drv(0, 1, 200, 10, 0);
    idle2();
    chk("t4_count", 32'(match_count), 32'd9);
    drv(1, 1, 200, 10, 1);
    idle2();
    chk("t4_clr_count", 32'(match_count), 32'd0);
    chk("t4_clr_last",  32'(spread_last), 32'd0);
    chk("t4_clr_valid", 32'(stats_valid), 32'd0);

    // Clear while a sample sits in S1 discards it.
    drv(1, 1, 30, 10, 0);
    drv(1, 0, 0, 0, 1);
    idle2();
    chk("t5_count", 32'(match_count), 32'd0);

    // Async reset right after an accept drops the in-flight sample.
    drv(1, 1, 40, 20, 0);
    @(negedge clk);
    match_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle2();
    chk("t6_count", 32'(match_count), 32'd0);
    chk("t6_valid", 32'(stats_valid), 32'd0);

    // Extreme spreads then a long run to saturate the narrow counter.
    drv(1, 1, 255, 0, 0);
    drv(1, 1, 0, 255, 0);
    for (int i = 0; i < 20; i++) drv(1, 1, (i * 37 + 11) % 256, (i * 91) % 256, 0);
    idle2();
    chk("t7_count",  32'(match_count), 32'd22);
    chk("t7_count4", 32'(l4_count),    32'd15);
    chk("t7_max",    32'(spread_max),  32'd255);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spread_stats.md
Name: spread_stats

Overview:
Parametrised successor to the single-value spread register in the matching engine. On every accepted match it computes the absolute bid/ask spread and keeps the following statistics for the VGA analytics overlay:
- last spread and the direction flag
- running min and max since the last clear
- a sliding-window average over the last DEPTH matches
- a saturating match count

It sits between the matching core's match strobe and the VGA analytics readout.

Parameters:
PRICE_W, 8, width of buy/sell prices and all spread outputs.
DEPTH, 8, sliding-window length in matches; power of two, 2..256.
CNT_W, 16, width of the match counter.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset; clock clk
enable_count  in  1  global statistics enable; samples are accepted only when high
match_valid  in  1  single-cycle match strobe from the matching core
buy_price  in  PRICE_W  price of the matched buy order
sell_price  in  PRICE_W  price of the matched sell order
clear  in  1  synchronous statistics clear
spread_last  out  PRICE_W  |buy-sell| of the most recent accepted match
buy_above  out  1  1 if the last accepted match had buy_price > sell_price
spread_min  out  PRICE_W  minimum spread since reset/clear
spread_max  out  PRICE_W  maximum spread since reset/clear
spread_avg  out  PRICE_W  window sum >> log2(DEPTH)
match_count  out  CNT_W  accepted matches since reset/clear; saturating
window_full  out  1  at least DEPTH matches accepted since reset/clear
stats_valid  out  1  at least one match accepted since reset/clear

Behaviour:
- Accept condition: enable_count && match_valid && !clear, evaluated at the clk rising edge. There is no backpressure; every cycle may carry a sample.
- Stage 1 (S1) registers abs_diff and the sign:
  - buy > sell: abs_diff = buy - sell, buy_above = 1
  - sell > buy: abs_diff = sell - buy, buy_above = 0
  - equal: abs_diff = 0, buy_above = 0
  - The subtraction never wraps.
- Stage 2 (S2) updates all statistics from S1. Latency: outputs reflect a sample 2 cycles after the accept edge. Back-to-back samples are fully pipelined.
- Window:
  - Circular buffer of DEPTH entries, all zero after reset/clear. Write pointer wraps DEPTH-1 -> 0.
  - sum width is PRICE_W + log2(DEPTH).
  - Update: sum_next = sum + new - evicted, where evicted is the entry at the write pointer (zero while not yet full).
- spread_avg = sum >> log2(DEPTH), truncating. Before window_full it is computed over zero-padded entries, so it is lower than the true mean. Consumers gate on window_full.
- Min/max:
  - The first sample after reset/clear loads both min and max.
  - Afterwards: min = min(min, s), max = max(max, s).
- match_count increments per S2 sample and saturates at 2^CNT_W-1.
- window_full is set when the fill counter reaches DEPTH and stays set until reset/clear.
- Reset (async) and clear (sync) have identical effect:
  - all outputs go to 0
  - buffer, sum, pointer and fill counter go to 0
  - the S1 valid bit is dropped, so an in-flight sample is discarded
- Priority: clear wins over a simultaneous accept and over an S2 update in the same cycle.
- Deasserting enable_count freezes the statistics but does not flush S1.

Decomposition:
- Shared header/package spread_pkg holds:
  - default PRICE_W/DEPTH/CNT_W
  - a clog2 function
  - derived localparams AW = log2(DEPTH) and SUM_W = PRICE_W + AW
- One sub-module, spread_window_buf, holds the circular buffer, write pointer, fill counter, running sum and window_full. Its interface is push, din, clear, sum, full.
- Top level owns S1, min/max, counter and output muxing.

Test Plan:
- Reset then buy=100, sell=90 accepted -> two cycles later spread_last=10, buy_above=1, min=max=10, count=1, stats_valid=1, window_full=0, avg=1 (10>>3).
- buy=50, sell=80; then buy=70, sell=70 -> spread_last=30 with buy_above=0, then spread_last=0; min=0, max=30.
- 8 matches with spreads 8,16,...,64 back-to-back -> window_full on the 8th, sum=288, avg=36. Then a 9th spread of 0 -> sum=280 (8 evicted), avg=35.
- match_valid=1 with enable_count=0 -> no output change. Then clear asserted in the same cycle as an accept -> all outputs 0, and that sample is never counted.
- Async reset pulse one cycle after an accept -> the S1 sample is discarded and outputs remain 0 after reset release.
- CNT_W=4 build, 20 matches -> match_count saturates at 15.
